// File: rtl/paula_uart_bridge_if.sv
// ---------------------------------------------------------------------------
// paula_uart_bridge_if
//   Host-side handshake bundle for the Paula UART bridge.
//
//   TX direction (host -> Paula rxd), push into the bridge FIFO:
//     host_tx_data  [8:0]  character to send (bit 8 used only in 9-bit mode)
//     host_tx_valid        host offers a character
//     host_tx_ready        bridge FIFO has room
//   RX direction (Paula txd -> host), pop from the one-entry holding register:
//     host_rx_data  [8:0]  received character (bit 8 = 0 in 8-bit mode)
//     host_rx_valid        holding register is occupied
//     host_rx_ready        host accepts the character
//
//   master: the host side.  slave: the bridge.
// ---------------------------------------------------------------------------
interface paula_uart_bridge_if;
    logic [8:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_ready;
    logic [8:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready;

    modport master (
        output host_tx_data,
        output host_tx_valid,
        input  host_tx_ready,
        input  host_rx_data,
        input  host_rx_valid,
        output host_rx_ready
    );

    modport slave (
        input  host_tx_data,
        input  host_tx_valid,
        output host_tx_ready,
        output host_rx_data,
        output host_rx_valid,
        input  host_rx_ready
    );
endinterface

// File: rtl/paula_uart_bridge.sv
// ---------------------------------------------------------------------------
// paula_uart_bridge
//   Serial bridge sitting on the Paula UART pins.
//   - Host characters are queued in a 2^FIFO_AW entry FIFO and serialised
//     onto rxd (start bit, 8 or 9 data bits LSB first, one stop bit).
//   - The txd line from Paula is synchronised, deserialised and presented
//     to the host through a one-entry holding register.
//   Bit timing advances only on clk edges with clk7_en = 1; the bit period
//   is baud_div[14:0] + 1 ticks, the same coding Paula's SERPER uses.
//
// Ports
//   clk, reset     system clock, asynchronous active-high reset
//   clk7_en        7 MHz tick enable
//   baud_div[15:0] bit period minus 1 (bit 15 unused)
//   long_fmt       1 = 9 data bits, 0 = 8 data bits
//   host           handshake bundle (slave modport)
//   rx_ovr_clr     clears rx_ovr
//   rxd            serial output into Paula rxd
//   txd            serial input from Paula txd
//   rx_ovr         sticky: a received character was dropped
//   frm_err        one-clk pulse on a bad stop bit
//   fifo_level     TX FIFO occupancy
// ---------------------------------------------------------------------------
module paula_uart_bridge #(
    parameter int FIFO_AW = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk7_en,
    input  logic [15:0]          baud_div,
    input  logic                 long_fmt,
    paula_uart_bridge_if.slave   host,
    input  logic                 rx_ovr_clr,
    output logic                 rxd,
    input  logic                 txd,
    output logic                 rx_ovr,
    output logic                 frm_err,
    output logic [FIFO_AW:0]     fifo_level
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [1:0] D_IDLE  = 2'd0;
    localparam logic [1:0] D_START = 2'd1;
    localparam logic [1:0] D_DATA  = 2'd2;
    localparam logic [1:0] D_STOP  = 2'd3;

    // Only the 15-bit period field of baud_div is meaningful.
    logic w_unused;
    assign w_unused = baud_div[15];

    // -----------------------------------------------------------------------
    // TX FIFO
    // -----------------------------------------------------------------------
    logic [8:0]       r_mem [DEPTH];
    logic [FIFO_AW:0] r_wptr;
    logic [FIFO_AW:0] r_rptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_push  = host.host_tx_valid && !w_full;

    assign host.host_tx_ready = !w_full;
    assign fifo_level         = r_wptr - r_rptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= host.host_tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
        end else if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Serializer: FIFO -> rxd
    // -----------------------------------------------------------------------
    logic [1:0]  r_sstate;
    logic [8:0]  r_tx_sh;
    logic [14:0] r_tx_div;
    logic        r_tx_fmt;
    logic [14:0] r_tx_cnt;
    logic [3:0]  r_tx_bit;
    logic        r_rxd;
    logic        w_tx_zero;
    logic        w_tx_last;
    logic        w_start;

    assign w_tx_zero = (r_tx_cnt == 15'd0);
    // r_tx_bit indexes the data bit currently on the line.
    assign w_tx_last = (r_tx_bit == (r_tx_fmt ? 4'd8 : 4'd7));

    // A frame starts from idle, or straight out of the final stop tick so
    // queued characters go out back-to-back with no idle gap.
    assign w_start = clk7_en && !w_empty &&
                     ((r_sstate == S_IDLE) || ((r_sstate == S_STOP) && w_tx_zero));

    assign rxd = r_rxd;

    // Frame data and the per-frame timing/format snapshot.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_tx_sh  <= r_mem[r_rptr[FIFO_AW-1:0]];
            r_tx_div <= baud_div[14:0];
            r_tx_fmt <= long_fmt;
        end else if (clk7_en && w_tx_zero &&
                     ((r_sstate == S_START) || (r_sstate == S_DATA))) begin
            r_tx_sh <= {1'b0, r_tx_sh[8:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sstate <= S_IDLE;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_rxd    <= 1'b1;
            r_rptr   <= '0;
        end else if (clk7_en) begin
            if (w_start) begin
                r_rptr   <= r_rptr + 1'b1;
                r_tx_cnt <= baud_div[14:0];
                r_rxd    <= 1'b0;
                r_sstate <= S_START;
            end else if (r_sstate == S_IDLE) begin
                r_rxd <= 1'b1;
            end else if (!w_tx_zero) begin
                r_tx_cnt <= r_tx_cnt - 1'b1;
            end else begin
                // End of the current bit period.
                r_tx_cnt <= r_tx_div;
                case (r_sstate)
                    S_START: begin
                        r_rxd    <= r_tx_sh[0];
                        r_tx_bit <= '0;
                        r_sstate <= S_DATA;
                    end
                    S_DATA: begin
                        if (w_tx_last) begin
                            r_rxd    <= 1'b1;
                            r_sstate <= S_STOP;
                        end else begin
                            r_rxd    <= r_tx_sh[0];
                            r_tx_bit <= r_tx_bit + 1'b1;
                        end
                    end
                    default: begin
                        r_rxd    <= 1'b1;
                        r_sstate <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Deserializer: txd -> holding register
    // -----------------------------------------------------------------------
    logic [1:0]  r_sync;
    logic        r_line_prev;
    logic [1:0]  r_dstate;
    logic [14:0] r_rx_cnt;
    logic [3:0]  r_rx_bit;
    logic [8:0]  r_rx_sh;
    logic [8:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_rx_ovr;
    logic        r_frm_err;
    logic        w_line;
    logic        w_rx_zero;
    logic        w_rx_last;
    logic        w_stop_evt;
    logic        w_hold_free;
    logic [8:0]  w_rx_word;

    assign w_line      = r_sync[1];
    assign w_rx_zero   = (r_rx_cnt == 15'd0);
    assign w_rx_last   = (r_rx_bit == (long_fmt ? 4'd8 : 4'd7));
    assign w_stop_evt  = clk7_en && (r_dstate == D_STOP) && w_rx_zero;
    // The holding register may be refilled on the same edge the host pops it.
    assign w_hold_free = !r_rx_valid || host.host_rx_ready;
    // Bits enter at the top, so an 8-bit character ends up in [8:1].
    assign w_rx_word   = long_fmt ? r_rx_sh : {1'b0, r_rx_sh[8:1]};

    assign host.host_rx_data  = r_rx_data;
    assign host.host_rx_valid = r_rx_valid;
    assign rx_ovr             = r_rx_ovr;
    assign frm_err            = r_frm_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync      <= 2'b11;
            r_line_prev <= 1'b1;
        end else if (clk7_en) begin
            r_sync      <= {r_sync[0], txd};
            r_line_prev <= r_sync[1];
        end
    end

    always_ff @(posedge clk) begin
        if (clk7_en && (r_dstate == D_DATA) && w_rx_zero) begin
            r_rx_sh <= {w_line, r_rx_sh[8:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dstate <= D_IDLE;
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
        end else if (clk7_en) begin
            case (r_dstate)
                D_IDLE: begin
                    // Half-period load centres every later sample in its bit.
                    if (r_line_prev && !w_line) begin
                        r_rx_cnt <= {1'b0, baud_div[14:1]};
                        r_dstate <= D_START;
                    end
                end
                D_START: begin
                    if (!w_rx_zero) begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end else if (!w_line) begin
                        r_rx_cnt <= baud_div[14:0];
                        r_rx_bit <= '0;
                        r_dstate <= D_DATA;
                    end else begin
                        r_dstate <= D_IDLE;
                    end
                end
                D_DATA: begin
                    if (!w_rx_zero) begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end else begin
                        r_rx_cnt <= baud_div[14:0];
                        r_rx_bit <= r_rx_bit + 1'b1;
                        if (w_rx_last) begin
                            r_dstate <= D_STOP;
                        end
                    end
                end
                default: begin
                    if (!w_rx_zero) begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end else begin
                        r_dstate <= D_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            if (w_stop_evt && w_line && w_hold_free) begin
                r_rx_data  <= w_rx_word;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && host.host_rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            // Set wins over a simultaneous clear.
            if (w_stop_evt && w_line && !w_hold_free) begin
                r_rx_ovr <= 1'b1;
            end else if (rx_ovr_clr) begin
                r_rx_ovr <= 1'b0;
            end

            r_frm_err <= w_stop_evt && !w_line;
        end
    end

endmodule

// File: tb/tb_paula_uart_bridge.sv
`timescale 1ns/1ps
module tb_paula_uart_bridge;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk7_en = 1'b0;
    logic [15:0] baud_div;
    logic        long_fmt;
    logic        rx_ovr_clr;
    logic        rxd;
    logic        txd_drv;
    logic        loop;
    wire         txd = loop ? rxd : txd_drv;
    logic        rx_ovr;
    logic        frm_err;
    logic [AW:0] fifo_level;

    paula_uart_bridge_if bus();

    paula_uart_bridge #(.FIFO_AW(AW)) dut (
        .clk        (clk),
        .reset      (rst),
        .clk7_en    (clk7_en),
        .baud_div   (baud_div),
        .long_fmt   (long_fmt),
        .host       (bus),
        .rx_ovr_clr (rx_ovr_clr),
        .rxd        (rxd),
        .txd        (txd),
        .rx_ovr     (rx_ovr),
        .frm_err    (frm_err),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // clk7_en: one tick every en_div clocks while en_on
    int unsigned tick_cnt = 0;
    int          en_div   = 2;
    bit          en_on    = 1'b1;
    int          ph       = 0;
    initial begin
        forever begin
            @(posedge clk);
            if (clk7_en) tick_cnt++;
            #1;
            ph      = (ph + 1 >= en_div) ? 0 : ph + 1;
            clk7_en = en_on && (ph == 0);
        end
    end

    // frm_err high-cycle counter
    int frm_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (frm_err === 1'b1) frm_cnt++;
        end
    end

    // ---------------- behavioural model of the TX side ----------------
    // Queue of accepted characters; the line is a timeline: a frame of
    // (n+2) bits, each P ticks, bit k of the frame = {stop, data, start}.
    logic [8:0] q[$];
    bit         m_busy;
    int         m_pos, m_P, m_n;
    logic [8:0] m_word;
    logic       m_rxd;

    function automatic logic fbit(input logic [8:0] w, input int n, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= n) return w[idx-1];
        return 1'b1;
    endfunction

    initial begin
        bit can_push;
        m_busy = 1'b0;
        m_rxd  = 1'b1;
        m_pos  = 0;
        m_P    = 1;
        m_n    = 8;
        m_word = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_busy = 1'b0;
                m_rxd  = 1'b1;
            end else begin
                can_push = (q.size() < DEPTH);
                if (clk7_en) begin
                    if (m_busy) begin
                        m_pos++;
                        if (m_pos >= (m_n + 2) * m_P) m_busy = 1'b0;
                    end
                    if (!m_busy && q.size() != 0) begin
                        m_word = q.pop_front();
                        m_P    = int'(baud_div[14:0]) + 1;
                        m_n    = long_fmt ? 9 : 8;
                        m_pos  = 0;
                        m_busy = 1'b1;
                    end
                    m_rxd = m_busy ? fbit(m_word, m_n, m_pos / m_P) : 1'b1;
                end
                if (bus.host_tx_valid && can_push) q.push_back(bus.host_tx_data);
            end
        end
    end

    // per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            check("model_rxd", 32'(rxd), 32'(m_rxd));
            check("model_level", 32'(fifo_level), 32'(q.size()));
            check("model_tx_ready", 32'(bus.host_tx_ready), 32'(q.size() < DEPTH));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            do begin
                @(posedge clk);
                g++;
            end while (!clk7_en && g < 64);
            if (g >= 64) check("tick_timeout", 32'(g), 32'(0));
        end
        #2;
    endtask

    task automatic push(input logic [8:0] d);
        int g = 0;
        @(negedge clk);
        bus.host_tx_data  = d;
        bus.host_tx_valid = 1'b1;
        while (!bus.host_tx_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) check("push_timeout", 32'(g), 32'(0));
        @(posedge clk);
        #2;
        bus.host_tx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [8:0] w, input int n, input logic stopb, input int p);
        wait_ticks(1);
        for (int k = 0; k < n + 2; k++) begin
            txd_drv = (k == n + 1) ? stopb : fbit(w, n, k);
            wait_ticks(p);
        end
        txd_drv = 1'b1;
    endtask

    task automatic pop_rx();
        @(negedge clk);
        bus.host_rx_ready = 1'b1;
        @(posedge clk);
        #2;
        bus.host_rx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [9:0] pat;
        int g;
        int unsigned t0;
        int unsigned t1;

        rst = 1'b1;
        baud_div = 16'd3;
        long_fmt = 1'b0;
        rx_ovr_clr = 1'b0;
        loop = 1'b0;
        txd_drv = 1'b1;
        bus.host_tx_valid = 1'b0;
        bus.host_tx_data  = '0;
        bus.host_rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_rxd", 32'(rxd), 32'(1));
        check("rst_tx_ready", 32'(bus.host_tx_ready), 32'(1));
        check("rst_rx_valid", 32'(bus.host_rx_valid), 32'(0));
        check("rst_rx_data", 32'(bus.host_rx_data), 32'(0));
        check("rst_rx_ovr", 32'(rx_ovr), 32'(0));
        check("rst_frm_err", 32'(frm_err), 32'(0));
        check("rst_level", 32'(fifo_level), 32'(0));
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 0xA5, 8 bits, period 4 ticks
        push(9'h0A5);
        check("a5_level_after_push", 32'(fifo_level), 32'(1));
        wait_ticks(1);
        check("a5_level_at_start", 32'(fifo_level), 32'(0));
        pat = 10'b1101001010;
        for (int k = 0; k < 40; k++) begin
            check("a5_rxd_tick", 32'(rxd), 32'(pat[k/4]));
            wait_ticks(1);
        end
        check("a5_rxd_idle", 32'(rxd), 32'(1));

        // fill FIFO with ticks frozen, then drain back-to-back
        en_on = 1'b0;
        baud_div = 16'd1;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 8; i++) push(9'(8'h11 * (i + 1)));
        @(negedge clk);
        check("full_tx_ready", 32'(bus.host_tx_ready), 32'(0));
        check("full_level", 32'(fifo_level), 32'(8));
        en_on = 1'b1;
        push(9'h1AB);
        wait_ticks(9 * 20 + 6);
        check("drain_level", 32'(fifo_level), 32'(0));
        check("drain_rxd", 32'(rxd), 32'(1));

        // loopback, 9-bit 0x1F3
        baud_div = 16'd3;
        long_fmt = 1'b1;
        loop = 1'b1;
        push(9'h1F3);
        g = 0;
        do begin @(negedge clk); g++; end while (rxd !== 1'b0 && g < 500);
        check("loop_start_seen", 32'(g < 500), 32'(1));
        t0 = tick_cnt;
        g = 0;
        do begin @(negedge clk); g++; end while (bus.host_rx_valid !== 1'b1 && g < 2000);
        check("loop_valid_seen", 32'(g < 2000), 32'(1));
        t1 = tick_cnt;
        check("loop_latency_ticks", t1 - t0, 32'(45));
        check("loop_rx_data", 32'(bus.host_rx_data), 32'h1F3);
        check("loop_frm_err", 32'(frm_cnt), 32'(0));
        wait_ticks(4);
        loop = 1'b0;
        pop_rx();
        check("loop_pop_valid", 32'(bus.host_rx_valid), 32'(0));

        // framing error: stop bit 0
        long_fmt = 1'b0;
        send_frame(9'h03C, 8, 1'b0, 4);
        wait_ticks(8);
        check("frm_pulse_cycles", 32'(frm_cnt), 32'(1));
        check("frm_rx_valid", 32'(bus.host_rx_valid), 32'(0));
        check("frm_rx_ovr", 32'(rx_ovr), 32'(0));

        // two frames without popping -> overrun
        send_frame(9'h05A, 8, 1'b1, 4);
        wait_ticks(4);
        check("ovr_first_valid", 32'(bus.host_rx_valid), 32'(1));
        check("ovr_first_data", 32'(bus.host_rx_data), 32'h05A);
        check("ovr_not_yet", 32'(rx_ovr), 32'(0));
        send_frame(9'h0C3, 8, 1'b1, 4);
        wait_ticks(4);
        check("ovr_set", 32'(rx_ovr), 32'(1));
        check("ovr_data_held", 32'(bus.host_rx_data), 32'h05A);
        check("ovr_valid_held", 32'(bus.host_rx_valid), 32'(1));
        @(negedge clk);
        rx_ovr_clr = 1'b1;
        @(posedge clk);
        #2;
        rx_ovr_clr = 1'b0;
        check("ovr_cleared", 32'(rx_ovr), 32'(0));
        pop_rx();
        check("ovr_pop_valid", 32'(bus.host_rx_valid), 32'(0));
        check("ovr_frm_none", 32'(frm_cnt), 32'(1));

        // 1-tick glitch with period 8 -> false start
        baud_div = 16'd7;
        wait_ticks(1);
        txd_drv = 1'b0;
        wait_ticks(1);
        txd_drv = 1'b1;
        wait_ticks(40);
        check("glitch_rx_valid", 32'(bus.host_rx_valid), 32'(0));
        check("glitch_frm", 32'(frm_cnt), 32'(1));
        check("glitch_ovr", 32'(rx_ovr), 32'(0));

        // reset in mid-frame
        push(9'h000);
        push(9'h155);
        wait_ticks(11);
        check("mid_rxd_low", 32'(rxd), 32'(0));
        check("mid_level", 32'(fifo_level), 32'(1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rxd", 32'(rxd), 32'(1));
        check("async_rst_level", 32'(fifo_level), 32'(0));
        check("async_rst_ready", 32'(bus.host_tx_ready), 32'(1));
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_ticks(20);
        check("post_rst_rxd", 32'(rxd), 32'(1));
        check("post_rst_level", 32'(fifo_level), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
